// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the adder_arbiter block: FSM state encoding,
// default widths and the owner-id to one-hot helper.
package adder_arb_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic [1:0] owner_onehot(input logic id);
        logic [1:0] oh;
        if (id) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester-side bundle of adder_arbiter: two request/response channels.
// master = requester side, slave = arbiter side.
interface adder_arbiter_if
    import adder_arb_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) ();

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_a0;
    logic [DATA_W-1:0] req_b0;
    logic [DATA_W-1:0] req_a1;
    logic [DATA_W-1:0] req_b1;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [DATA_W:0]   rsp_sum;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_sum
    );

endinterface

// File: rtl/adder_arbiter_rr.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// requester named by ptr.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // One-hot grant selection
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (ptr) begin
                    gnt = 2'b10;
                end else begin
                    gnt = 2'b01;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one external adder between two requesters: IDLE grants, CALC captures
// the sum, RESP holds it until the owner accepts. Optional grant counters are
// enabled with ADDER_ARB_STATS_EN.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    adder_arbiter_if.slave    bus,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    input  logic [DATA_W:0]   add_s
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
`endif
);

    if ((DATA_W < 1) || (CNT_W < 1)) begin : g_param_check
        $error("adder_arbiter: DATA_W and CNT_W must be positive");
    end

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] add_a_q, add_a_d;
    logic [DATA_W-1:0] add_b_q, add_b_d;
    logic [DATA_W:0]   rsp_sum_q, rsp_sum_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;

    logic [1:0]        gnt_s;
    logic [1:0]        req_ready_s;
    logic              hs_s;
    logic              hs_id_s;

    rr_arbiter2 u_rr (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .gnt (gnt_s)
    );

    // Accept strobe is live only in IDLE; rst_n gates it so reset forces it low
    always_comb begin
        if ((state_q == IDLE) && rst_n) begin
            req_ready_s = gnt_s;
        end else begin
            req_ready_s = 2'b00;
        end
        hs_s    = |(bus.req_valid & req_ready_s);
        hs_id_s = req_ready_s[1];
    end

    // Next-state and datapath sequencing
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (hs_s) begin
                    if (hs_id_s) begin
                        add_a_d = bus.req_a1;
                        add_b_d = bus.req_b1;
                    end else begin
                        add_a_d = bus.req_a0;
                        add_b_d = bus.req_b0;
                    end
                    owner_d = hs_id_s;
                    ptr_d   = ~hs_id_s;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                rsp_sum_d   = add_s;
                rsp_valid_d = owner_onehot(owner_q);
                state_d     = RESP;
            end
            RESP: begin
                // Only the owner's accept counts; the other bit is ignored
                if (bus.rsp_ready[owner_q]) begin
                    rsp_valid_d = 2'b00;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                rsp_valid_d = 2'b00;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            add_a_q     <= {DATA_W{1'b0}};
            add_b_q     <= {DATA_W{1'b0}};
            rsp_sum_q   <= {(DATA_W+1){1'b0}};
            rsp_valid_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef ADDER_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
    logic [CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;

    // Saturating per-requester grant counters
    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (hs_s && !hs_id_s && (grant_cnt0_q != CNT_MAX)) begin
            grant_cnt0_d = grant_cnt0_q + CNT_ONE;
        end else begin
            grant_cnt0_d = grant_cnt0_q;
        end
        if (hs_s && hs_id_s && (grant_cnt1_q != CNT_MAX)) begin
            grant_cnt1_d = grant_cnt1_q + CNT_ONE;
        end else begin
            grant_cnt1_d = grant_cnt1_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0_q <= {CNT_W{1'b0}};
            grant_cnt1_q <= {CNT_W{1'b0}};
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

    assign add_a         = add_a_q;
    assign add_b         = add_b_q;
    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: vector table through a scoreboard,
// plus hand sequences for reset, stall, abort and (optionally) grant counters.
module tb_adder_arbiter;
    import adder_arb_pkg::*;

    localparam int DW = 8;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adder_arbiter_if #(.DATA_W(DW)) bus ();

    logic [DW-1:0] add_a, add_b;
    logic [DW:0]   add_s;
    assign add_s = {1'b0, add_a} + {1'b0, add_b};

`ifdef ADDER_ARB_STATS_EN
    logic [CW-1:0] grant_cnt0, grant_cnt1;
`endif

    adder_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .add_a (add_a),
        .add_b (add_b),
        .add_s (add_s)
`ifdef ADDER_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    typedef struct {
        logic [1:0]    v;
        logic [DW-1:0] a0, b0, a1, b1;
        logic [1:0]    gnt;
        logic [DW:0]   sum;
    } vec_t;

    typedef struct {
        logic [1:0]  owner;
        logic [DW:0] sum;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'h0);
        check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        check({tag, " rsp_sum"},   32'(bus.rsp_sum),   32'h0);
        check({tag, " add_a"},     32'(add_a),         32'h0);
        check({tag, " add_b"},     32'(add_b),         32'h0);
`ifdef ADDER_ARB_STATS_EN
        check({tag, " cnt0"},      32'(grant_cnt0),    32'h0);
        check({tag, " cnt1"},      32'(grant_cnt1),    32'h0);
`endif
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_reset();
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b00;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("reset");
        bus.req_valid = 2'b00;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'(sb.size()), 32'h1);
        end else begin
            e = sb.pop_front();
            check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(e.owner));
            check({tag, " rsp_sum"},   32'(bus.rsp_sum),   32'(e.sum));
        end
    endtask

    // One full operation; req_valid stays held through CALC/RESP.
    task automatic do_op(input logic [1:0] v,
                         input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                         input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                         input logic [1:0] eg, input logic [DW:0] es);
        exp_t e;
        logic [DW-1:0] ea, eb;
        ea = (eg == 2'b10) ? a1 : a0;
        eb = (eg == 2'b10) ? b1 : b0;
        bus.req_valid = v;
        bus.req_a0 = a0; bus.req_b0 = b0;
        bus.req_a1 = a1; bus.req_b1 = b1;
        #1;
        check("idle req_ready", 32'(bus.req_ready), 32'(eg));
        e.owner = eg;
        e.sum   = es;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check("calc req_ready", 32'(bus.req_ready), 32'h0);
        check("calc rsp_valid", 32'(bus.rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        pop_compare("resp");
        check("resp req_ready", 32'(bus.req_ready), 32'h0);
        check("resp add_a", 32'(add_a), 32'(ea));
        check("resp add_b", 32'(add_b), 32'(eb));
        bus.rsp_ready = eg;
        @(posedge clk);
        #1;
        bus.rsp_ready = 2'b00;
        check("done rsp_valid", 32'(bus.rsp_valid), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b01, 8'h12, 8'h34, 8'h99, 8'h99, 2'b01, 9'h046};
        vecs[1] = '{2'b11, 8'h01, 8'h01, 8'hFF, 8'hFF, 2'b10, 9'h1FE};
        vecs[2] = '{2'b11, 8'h01, 8'h01, 8'hFF, 8'hFF, 2'b01, 9'h002};
        vecs[3] = '{2'b10, 8'h00, 8'h00, 8'h80, 8'h80, 2'b10, 9'h100};
        vecs[4] = '{2'b10, 8'h11, 8'h11, 8'h00, 8'h00, 2'b10, 9'h000};
        vecs[5] = '{2'b01, 8'hFF, 8'h01, 8'h22, 8'h22, 2'b01, 9'h100};
        vecs[6] = '{2'b01, 8'h7F, 8'h80, 8'h33, 8'h33, 2'b01, 9'h0FF};
        vecs[7] = '{2'b11, 8'hAA, 8'h55, 8'h03, 8'h04, 2'b10, 9'h007};

        rst_n = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        bus.req_a0 = 8'h00; bus.req_b0 = 8'h00;
        bus.req_a1 = 8'h00; bus.req_b1 = 8'h00;
        #3;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].v, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
                  vecs[i].gnt, vecs[i].sum);
        end
        bus.req_valid = 2'b00;

        // Both requesting from reset: r0 first, then r1
        do_reset();
        do_op(2'b11, 8'h01, 8'h01, 8'hFF, 8'hFF, 2'b01, 9'h002);
        do_op(2'b11, 8'h01, 8'h01, 8'hFF, 8'hFF, 2'b10, 9'h1FE);
        bus.req_valid = 2'b00;

        // Stall in RESP with non-owner accept asserted
        do_reset();
        bus.req_valid = 2'b11;
        bus.req_a0 = 8'h21; bus.req_b0 = 8'h10;
        bus.req_a1 = 8'h05; bus.req_b1 = 8'h06;
        #1;
        check("stall ready", 32'(bus.req_ready), 32'h1);
        sb.push_back('{2'b01, 9'h031});
        @(posedge clk); #1;
        @(posedge clk); #1;
        pop_compare("stall first");
        bus.rsp_ready = 2'b10;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("stall rsp_valid", 32'(bus.rsp_valid), 32'h1);
            check("stall rsp_sum",   32'(bus.rsp_sum),   32'h031);
            check("stall req_ready", 32'(bus.req_ready), 32'h0);
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b01;
        @(posedge clk); #1;
        bus.rsp_ready = 2'b00;
        check("stall release", 32'(bus.rsp_valid), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("dropped req ready", 32'(bus.req_ready), 32'h0);
            check("dropped req rsp",   32'(bus.rsp_valid), 32'h0);
        end

        // Reset asserted during CALC aborts the operation
        do_reset();
        bus.req_valid = 2'b01;
        bus.req_a0 = 8'h40; bus.req_b0 = 8'h40;
        @(posedge clk); #1;
        check("abort calc add_a", 32'(add_a), 32'h40);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("abort");
        bus.req_valid = 2'b00;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("post-abort rsp_valid", 32'(bus.rsp_valid), 32'h0);
            check("post-abort rsp_sum",   32'(bus.rsp_sum),   32'h0);
        end
        bus.req_valid = 2'b11;
        #1;
        check("post-abort ptr", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 2'b00;
        @(posedge clk); #1;

`ifdef ADDER_ARB_STATS_EN
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            do_op(2'b01, 8'(k), 8'(k), 8'h00, 8'h00, 2'b01, 9'(2 * k));
            check("grant_cnt0", 32'(grant_cnt0), 32'((k < 3) ? k : 3));
            check("grant_cnt1", 32'(grant_cnt1), 32'h0);
        end
        bus.req_valid = 2'b00;
`endif

        check("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: operand width; the sum is DATA_W+1 bits.
REQ-002 Parameter CNT_W, default 16: width of each grant counter; used only with ADDER_ARB_STATS_EN.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  2  per-requester operation request; bit i belongs to requester i.
REQ-006 req_ready  output  2  per-requester accept strobe.
REQ-007 req_a0, req_b0  input  DATA_W each  requester 0 operands.
REQ-008 req_a1, req_b1  input  DATA_W each  requester 1 operands.
REQ-009 add_a, add_b  output  DATA_W each  operands driven to the shared adder (A_0/B_0).
REQ-010 add_s  input  DATA_W+1  combinational sum returned from the shared adder (S_0).
REQ-011 rsp_valid  output  2  per-requester result valid.
REQ-012 rsp_ready  input  2  per-requester result accept.
REQ-013 rsp_sum  output  DATA_W+1  result, meaningful only while rsp_valid is nonzero.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and RESP.
REQ-015 IDLE: req_ready SHALL be one-hot for the granted requester, or zero when req_valid==0; it is combinational from req_valid and the round-robin pointer.
REQ-016 If exactly one req_valid bit is set, that requester SHALL be granted regardless of the pointer.
REQ-017 If both bits are set, the requester named by the pointer SHALL be granted.
REQ-018 On a handshake (req_valid[i] & req_ready[i]), the block SHALL register that requester's operands into add_a/add_b, record owner id i, set the pointer to the other requester, and move to CALC.
REQ-019 CALC: req_ready SHALL be 0; add_s SHALL be captured into rsp_sum; the FSM SHALL move to RESP.
REQ-020 RESP: rsp_valid SHALL be one-hot on the owner bit and rsp_sum SHALL hold stable until rsp_ready[owner] is high.
REQ-021 When rsp_ready[owner] is high in RESP, the FSM SHALL return to IDLE on the next edge.
REQ-022 rsp_ready on the non-owner bit SHALL be ignored.
REQ-023 Latency: rsp_valid SHALL rise exactly 2 cycles after the request handshake edge.
REQ-024 Minimum throughput SHALL be one operation per 3 cycles.
REQ-025 add_a/add_b SHALL hold their last operands outside CALC.
REQ-026 The sum is unsigned with the carry in the MSB; 0xFF+0xFF SHALL give 0x1FE.
REQ-027 A requester that drops req_valid before it is granted SHALL have no effect.
REQ-028 A new request SHALL never be accepted in CALC or RESP.

Reset
REQ-029 While rst_n is low the block SHALL force: state IDLE, pointer 0, add_a/add_b 0, rsp_sum 0, rsp_valid 0, req_ready 0, and counters 0.
REQ-030 An assertion of rst_n mid-operation SHALL abort the operation; the in-flight result is discarded and no rsp_valid is issued after release.

Configuration
REQ-031 With ADDER_ARB_STATS_EN defined, the block SHALL add output ports grant_cnt0 and grant_cnt1 (CNT_W each).
REQ-032 With ADDER_ARB_STATS_EN defined, grant_cnt0/grant_cnt1 SHALL increment on each handshake of requester 0/1 and saturate at all-ones.
REQ-033 Without ADDER_ARB_STATS_EN, these ports and counters SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-034 Package adder_arb_pkg SHALL hold the state enum (IDLE/CALC/RESP) and the default DATA_W constant.
REQ-035 Grant selection SHALL be a sub-module rr_arbiter2: inputs req[1:0] and ptr; output one-hot gnt.
REQ-036 The adder itself SHALL stay external; this block only sequences it.

Verification
REQ-037 Reset, then req_valid=01, a0=0x12, b0=0x34: ready[0] is set in the same cycle; rsp_valid=01 with rsp_sum=0x046 two cycles later.
REQ-038 Both valid from reset, r0 (a0=0x01, b0=0x01), r1 (a1=0xFF, b1=0xFF): r0 is served first with sum 0x002, then r1 with sum 0x1FE; responses alternate.
REQ-039 Hold rsp_ready=0 for 5 cycles in RESP: rsp_valid and rsp_sum stay stable and req_ready stays 00 throughout.
REQ-040 Pulse rst_n low during CALC: all outputs go to 0 immediately, and no rsp_valid appears after release.
REQ-041 With ADDER_ARB_STATS_EN and CNT_W=2, issue 5 grants to r0: grant_cnt0 saturates at 3 and grant_cnt1 stays 0.
